// File: rtl/n_rot_pkg.sv
// Shared constants, packet field layout and watchdog state encoding for the rotation tagger.
// Also holds the saturating-increment helper used by the event counters.
package n_rot_pkg;

    localparam logic [7:0] HEADER = 8'h55;

    // Packet layout: byte 0 is the header, bytes 1..4 the rotation count (byte 1 = LSB).
    localparam int unsigned PKT_W   = 40;
    localparam int unsigned HDR_LSB = 0;
    localparam int unsigned HDR_W   = 8;
    localparam int unsigned ROT_LSB = 8;
    localparam int unsigned ROT_W   = 32;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        NOSIG,
        LIVE,
        STALE
    } wd_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/n_rot_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// A word pushed into an empty FIFO is presented one cycle after it is written.
module n_rot_fifo #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_en,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [LW-1:0]    resident;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push, pop;

    always_comb begin
        full     = (level_q == DEPTH_L);
        push     = push_en && !full;
        pop      = out_valid_q && out_ready;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        // Only words already resident before this edge may become the head, which gives
        // the two-cycle latency from an empty FIFO and never exposes a half-written slot.
        resident    = level_q - LW'(pop);
        out_valid_d = (resident != '0);
        out_data_d  = out_valid_d ? mem[rd_ptr_d] : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = level_q;

endmodule

// File: rtl/n_rot_tagger.sv
// Tags good rotation-count packets with the system timestamp and queues them, while tracking
// header errors, overflow drops, the latest rotation count and signal staleness.
module n_rot_tagger #(
    parameter logic [7:0]  HEADER  = n_rot_pkg::HEADER,
    parameter int unsigned TS_W    = 48,
    parameter int unsigned DEPTH   = 16,
    parameter logic [31:0] TIMEOUT = 32'd20_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [39:0]               in_q,
    input  logic [TS_W-1:0]           ts,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [TS_W+31:0]          out_data,
    output logic [31:0]               rot_latest,
    output logic                      stale,
    output logic [15:0]               hdr_err_cnt,
    output logic [15:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]    level
);

    import n_rot_pkg::*;

    localparam logic [31:0] AGE_LIM = TIMEOUT - 32'd1;

    logic              good, bad;
    logic [ROT_W-1:0]  rot;
    logic              fifo_full;
    logic [TS_W+31:0]  push_data;

    wd_state_e         state_q;
    logic [31:0]       age_q;
    logic              age_hit;

    always_comb begin
        good      = in_valid && (in_q[HDR_LSB +: HDR_W] == HEADER);
        bad       = in_valid && (in_q[HDR_LSB +: HDR_W] != HEADER);
        rot       = in_q[ROT_LSB +: ROT_W];
        push_data = {ts, rot};
        // Widened compare so a near-maximum age cannot wrap when incremented.
        age_hit   = ({1'b0, age_q} + 33'd1) >= {1'b0, AGE_LIM};
    end

    n_rot_fifo #(
        .WIDTH (TS_W + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_en   (good),
        .push_data (push_data),
        .full      (fifo_full),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rot_latest  <= '0;
            hdr_err_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (good) begin
                rot_latest <= rot;
            end
            if (bad) begin
                hdr_err_cnt <= sat_inc(hdr_err_cnt);
            end
            // Full is judged on the pre-edge level, so a same-cycle pop does not save it.
            if (good && fifo_full) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NOSIG;
            age_q   <= '0;
            stale   <= 1'b1;
        end else begin
            stale <= (state_q != LIVE);
            unique case (state_q)
                NOSIG: begin
                    if (good) begin
                        state_q <= LIVE;
                        age_q   <= '0;
                    end
                end
                LIVE: begin
                    if (good) begin
                        age_q <= '0;
                    end else if (age_hit) begin
                        state_q <= STALE;
                        age_q   <= AGE_LIM;
                    end else begin
                        age_q <= age_q + 32'd1;
                    end
                end
                STALE: begin
                    if (good) begin
                        state_q <= LIVE;
                        age_q   <= '0;
                    end
                end
                default: begin
                    state_q <= NOSIG;
                    age_q   <= '0;
                end
            endcase
        end
    end

endmodule
